// File: rtl/pipe_pkg.sv
// Shared types and default sizes for the pipeline skid stage.
package pipe_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned CTRL_W_DEF = 8;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } pipe_state_t;

  // Entry count held in a given state.
  function automatic logic [1:0] occ_of(input pipe_state_t s);
    logic [1:0] occ;
    case (s)
      ONE:     occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  input  logic         clr_sync,
  output logic [W-1:0] count
);

  // Count up to all-ones and stick there; clr_sync has priority.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= '0;
    end else if (clr_sync) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready pipeline stage: main register drives outputs, skid
// register absorbs one extra entry so in_ready can be a pure flop.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned CTRL_W = CTRL_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              flush,
  input  logic              cnt_clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_t       state_q, state_nx;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_nx;
  logic [WIDTH-1:0]  main_data_q, main_data_nx;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_nx;
  logic [WIDTH-1:0]  skid_data_q, skid_data_nx;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        occupancy_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid_q & out_ready;

  // Next-state and payload steering; flush overrides every transfer.
  always_comb begin
    state_nx     = state_q;
    main_ctrl_nx = main_ctrl_q;
    main_data_nx = main_data_q;
    skid_ctrl_nx = skid_ctrl_q;
    skid_data_nx = skid_data_q;
    if (flush) begin
      state_nx     = EMPTY;
      main_ctrl_nx = '0;
      skid_ctrl_nx = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_ctrl_nx = in_ctrl;
            main_data_nx = in_data;
            state_nx     = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl_nx = in_ctrl;
            main_data_nx = in_data;
          end else if (in_fire) begin
            skid_ctrl_nx = in_ctrl;
            skid_data_nx = in_data;
            state_nx     = FULL;
          end else if (out_fire) begin
            // Bubble: ctrl goes to zero, data keeps its last value.
            main_ctrl_nx = '0;
            state_nx     = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_ctrl_nx = skid_ctrl_q;
            main_data_nx = skid_data_q;
            state_nx     = ONE;
          end
        end
        default: begin
          state_nx = EMPTY;
        end
      endcase
    end
  end

  // State, payload and registered handshake/status outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occupancy_q <= 2'd0;
    end else begin
      state_q     <= state_nx;
      main_ctrl_q <= main_ctrl_nx;
      main_data_q <= main_data_nx;
      skid_ctrl_q <= skid_ctrl_nx;
      skid_data_q <= skid_data_nx;
      in_ready_q  <= (state_nx != FULL);
      out_valid_q <= (state_nx != EMPTY);
      occupancy_q <= occ_of(state_nx);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occupancy_q;

  // Backpressure cycles: entry presented but not taken.
  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk      (clk),
    .clr      (clr),
    .inc      (out_valid_q & ~out_ready),
    .clr_sync (cnt_clr),
    .count    (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed vector table plus corner sequences and a randomised queue check.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        clr;
  logic        flush;
  logic        cnt_clr;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_ctrl;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ctrl;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [3:0]  stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_skid_stage #(
    .WIDTH (32),
    .CTRL_W(8),
    .CNT_W (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .flush    (flush),
    .cnt_clr  (cnt_clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        cnt_clr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        e_ov;
    logic        e_ir;
    logic [1:0]  e_occ;
    logic [31:0] e_data;
    logic [7:0]  e_ctrl;
    logic [3:0]  e_stall;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic fl, input logic cc, input logic iv,
                              input logic [31:0] id, input logic ordy,
                              input logic eov, input logic eir,
                              input logic [1:0] eocc, input logic [31:0] ed,
                              input logic [7:0] ec, input logic [3:0] es);
    vec_t v;
    v.flush = fl; v.cnt_clr = cc; v.in_valid = iv; v.in_data = id;
    v.out_ready = ordy; v.e_ov = eov; v.e_ir = eir; v.e_occ = eocc;
    v.e_data = ed; v.e_ctrl = ec; v.e_stall = es;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic chk_all(input string tag, input logic eov, input logic eir,
                         input logic [1:0] eocc, input logic [31:0] ed,
                         input logic [7:0] ec, input logic [3:0] es);
    chk({tag, ".out_valid"}, 40'(out_valid), 40'(eov));
    chk({tag, ".in_ready"},  40'(in_ready),  40'(eir));
    chk({tag, ".occupancy"}, 40'(occupancy), 40'(eocc));
    chk({tag, ".out_data"},  40'(out_data),  40'(ed));
    chk({tag, ".out_ctrl"},  40'(out_ctrl),  40'(ec));
    chk({tag, ".stall_cnt"}, 40'(stall_cnt), 40'(es));
  endtask

  task automatic drive(input logic fl, input logic cc, input logic iv,
                       input logic [31:0] id, input logic ordy);
    flush = fl; cnt_clr = cc; in_valid = iv; in_data = id;
    in_ctrl = id[7:0]; out_ready = ordy;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [39:0] q[$];
  int          pushed;
  int          popped;
  logic        do_in;
  logic        do_out;

  initial begin
    clr = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    chk_all("reset", 0, 1, 2'd0, 32'h0, 8'h0, 4'd0);

    // Streaming, backpressure, flush-while-full and flush-with-delivery.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 0, 1, 32'(k), 1, 1, 1, 2'd1, 32'(k), 8'(k), 4'd0));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 0, 1, 2'd0, 32'h8,  8'h0,  4'd0));
    vecs.push_back(mk(0, 0, 1, 32'hA,  0, 1, 1, 2'd1, 32'hA,  8'hA,  4'd0));
    vecs.push_back(mk(0, 0, 1, 32'hB,  0, 1, 0, 2'd2, 32'hA,  8'hA,  4'd1));
    vecs.push_back(mk(0, 0, 1, 32'hD,  0, 1, 0, 2'd2, 32'hA,  8'hA,  4'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 1, 1, 2'd1, 32'hB,  8'hB,  4'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 0, 1, 2'd0, 32'hB,  8'h0,  4'd2));
    vecs.push_back(mk(0, 1, 1, 32'h21, 0, 1, 1, 2'd1, 32'h21, 8'h21, 4'd0));
    vecs.push_back(mk(0, 0, 1, 32'h22, 0, 1, 0, 2'd2, 32'h21, 8'h21, 4'd1));
    vecs.push_back(mk(1, 0, 1, 32'hC,  0, 0, 1, 2'd0, 32'h21, 8'h0,  4'd2));
    vecs.push_back(mk(0, 0, 0, 32'h0,  1, 0, 1, 2'd0, 32'h21, 8'h0,  4'd2));
    vecs.push_back(mk(0, 0, 1, 32'h33, 1, 1, 1, 2'd1, 32'h33, 8'h33, 4'd2));
    vecs.push_back(mk(1, 0, 1, 32'h44, 1, 0, 1, 2'd0, 32'h33, 8'h0,  4'd2));
    vecs.push_back(mk(0, 1, 0, 32'h0,  1, 0, 1, 2'd0, 32'h33, 8'h0,  4'd0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].cnt_clr, vecs[i].in_valid, vecs[i].in_data,
            vecs[i].out_ready);
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_ir, vecs[i].e_occ,
              vecs[i].e_data, vecs[i].e_ctrl, vecs[i].e_stall);
    end

    // Saturation: 20 stalled cycles on a 4-bit counter, then clear vs stall.
    drive(0, 0, 1, 32'h55, 0);
    step();
    drive(0, 0, 0, 32'h0, 0);
    repeat (20) step();
    chk_all("sat", 1, 1, 2'd1, 32'h55, 8'h55, 4'd15);
    drive(0, 1, 0, 32'h0, 0);
    step();
    chk("sat_clr.stall_cnt", 40'(stall_cnt), 40'd0);
    drive(0, 0, 0, 32'h0, 1);
    step();
    chk_all("sat_drain", 0, 1, 2'd0, 32'h55, 8'h0, 4'd0);

    // Asynchronous reset while FULL, between clock edges.
    drive(0, 0, 1, 32'h61, 0);
    step();
    drive(0, 0, 1, 32'h62, 0);
    step();
    chk("pre_rst.occupancy", 40'(occupancy), 40'd2);
    drive(0, 0, 0, 32'h0, 0);
    #2 clr = 1'b1;
    #1;
    chk_all("async_rst", 0, 1, 2'd0, 32'h0, 8'h0, 4'd0);
    #1 clr = 1'b0;
    drive(0, 0, 1, 32'h5, 1);
    step();
    chk_all("post_rst", 1, 1, 2'd1, 32'h5, 8'h5, 4'd0);
    drive(0, 0, 0, 32'h0, 1);
    step();
    chk_all("post_rst_drain", 0, 1, 2'd0, 32'h5, 8'h0, 4'd0);

    // Random valid/ready against a reference queue.
    pushed = 0;
    popped = 0;
    for (int c = 0; c < 10000; c++) begin
      drive(0, 0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      in_ctrl = 8'($urandom);
      if (occupancy != 2'(q.size()))
        chk($sformatf("rnd%0d.occupancy", c), 40'(occupancy), 40'(q.size()));
      if (occupancy == 2'd2 && in_ready)
        chk($sformatf("rnd%0d.in_ready_full", c), 40'(in_ready), 40'd0);
      if (out_valid !== (q.size() != 0))
        chk($sformatf("rnd%0d.out_valid", c), 40'(out_valid), 40'(q.size() != 0));
      do_in  = in_valid & in_ready;
      do_out = out_valid & out_ready;
      if (do_out && q.size() != 0) begin
        chk($sformatf("rnd%0d.out", c), {out_ctrl, out_data}, q[0]);
        void'(q.pop_front());
        popped++;
      end
      if (do_in) begin
        q.push_back({in_ctrl, in_data});
        pushed++;
      end
      step();
    end
    drive(0, 0, 0, 32'h0, 1);
    for (int c = 0; c < 4; c++) begin
      if (out_valid && q.size() != 0) begin
        chk($sformatf("drain%0d.out", c), {out_ctrl, out_data}, q[0]);
        void'(q.pop_front());
        popped++;
      end
      step();
    end
    chk("rnd.count", 40'(popped), 40'(pushed));
    chk("rnd.final_occ", 40'(occupancy), 40'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data payload width in bits.
REQ-002 SHALL have parameter CTRL_W, default 8, meaning control payload width in bits; this payload is zeroed on bubble or flush.
REQ-003 SHALL have parameter CNT_W, default 16, meaning stall counter width.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous flush request.
REQ-007 SHALL have port cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-008 SHALL have port in_valid  input  1  upstream entry valid.
REQ-009 SHALL have port in_ready  output  1  stage can accept, registered.
REQ-010 SHALL have port in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 SHALL have port in_data  input  WIDTH  upstream data payload.
REQ-012 SHALL have port out_valid  output  1  downstream entry valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts.
REQ-014 SHALL have port out_ctrl  output  CTRL_W  control payload, forced 0 when out_valid=0.
REQ-015 SHALL have port out_data  output  WIDTH  data payload, holds last value when out_valid=0.
REQ-016 SHALL have port occupancy  output  2  entry count, 0..2.
REQ-017 SHALL have port stall_cnt  output  CNT_W  saturating count of backpressure cycles.

Function
REQ-018 SHALL define in_fire = in_valid&in_ready and out_fire = out_valid&out_ready.
REQ-019 SHALL hold one main register (drives outputs) and one skid register; states EMPTY (0 entries), ONE (main valid), FULL (main+skid valid).
REQ-020 EMPTY: on in_fire SHALL load main from in and go to ONE; otherwise hold.
REQ-021 ONE: on in_fire&out_fire SHALL load main from in and stay ONE; on in_fire only SHALL load skid and go to FULL; on out_fire only SHALL go to EMPTY; otherwise hold.
REQ-022 FULL: on out_fire SHALL move skid to main and go to ONE; otherwise hold; in_fire is impossible in FULL.
REQ-023 SHALL drive in_ready=1 exactly when state is not FULL, from a flop with no combinational path from out_ready.
REQ-024 SHALL have latency of 1 cycle (in_fire at edge N gives out_valid=1 after edge N) and sustain 1 transfer/cycle when out_ready is held 1.
REQ-025 SHALL preserve order; no entry is lost or duplicated.
REQ-026 flush SHALL take priority over all transfers: next state EMPTY, main and skid ctrl fields set to 0, data fields held; an in_fire in that cycle is discarded.
REQ-027 An out_fire coinciding with flush SHALL count as delivered downstream.
REQ-028 SHALL drive occupancy as 0/1/2 for EMPTY/ONE/FULL.
REQ-029 SHALL increment stall_cnt each cycle out_valid=1 and out_ready=0, saturating at all-ones (no wrap).
REQ-030 When cnt_clr and an increment coincide, cnt_clr SHALL win; flush SHALL NOT affect stall_cnt.

Reset
REQ-031 clr SHALL immediately set: state EMPTY, in_ready 1, out_valid 0, out_ctrl 0, out_data 0, skid contents 0, occupancy 0, stall_cnt 0.
REQ-032 clr asserted mid-transfer SHALL discard all held entries; first acceptance SHALL occur at the first clk edge after clr deasserts.

Structure
REQ-033 Package pipe_pkg SHALL hold typedef pipe_state_t (EMPTY=2'b00, ONE=2'b01, FULL=2'b10) and default WIDTH/CTRL_W/CNT_W constants.
REQ-034 The stall counter SHALL be sub-module sat_counter (parameter W; inputs inc, clr_sync; output count).

Verification
REQ-035 Streaming: out_ready=1, in_valid=1, data 1..8 for 8 cycles -> out_data 1..8 on 8 consecutive cycles starting 1 cycle later; stall_cnt=0.
REQ-036 Backpressure: accept 0xA, 0xB with out_ready=0 -> occupancy=2, in_ready=0; raise out_ready -> out 0xA then 0xB; stall_cnt equals stalled cycles.
REQ-037 Flush when FULL with in_valid=1 (0xC) -> next cycle out_valid=0, out_ctrl=0, occupancy=0, 0xC never emitted.
REQ-038 Saturation: CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15; cnt_clr with a stall in the same cycle -> stall_cnt=0.
REQ-039 Async reset while FULL between edges -> outputs at reset values before next edge; next accepted entry 0x5 is emitted alone.
REQ-040 Random valid/ready (10k cycles) against a reference queue -> order and count match; in_ready never 1 while occupancy=2.
